// File: rtl/thunderbird_seq.sv
// thunderbird_seq: tail-light sequencer for N lamps per side.
//   Turn sweeps light a growing thermometer outward from the innermost lamp,
//   hazard flashes both sides via an IDLE<->HAZ loop, and brake forces every
//   side that is not sweeping to all-ones. State advances once every STEP
//   clk_1hz cycles.
// Ports:
//   clk_1hz       lamp clock, all state updates on its rising edge
//   reset         synchronous active-high reset
//   H, L, R       hazard / left / right requests, sampled only on a step tick
//   B             brake, combinational override
//   Left, Right   lamp outputs, bit 0 is the innermost lamp
//   busy          high whenever the sequencer is not idle
module thunderbird_seq #(
  parameter int unsigned N    = 3,
  parameter int unsigned STEP = 1
) (
  input  logic         clk_1hz,
  input  logic         reset,
  input  logic         H,
  input  logic         L,
  input  logic         R,
  input  logic         B,
  output logic [N-1:0] Left,
  output logic [N-1:0] Right,
  output logic         busy
);

  localparam int unsigned DivW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int unsigned KW   = $clog2(N + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(STEP - 1);
  localparam logic [KW-1:0]   KMax    = KW'(N);

  typedef enum logic [1:0] {StIdle, StLeft, StRight, StHaz} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [DivW-1:0] div_q;
  logic            tick;
  logic [N-1:0]    left_q, right_q;
  logic            busy_q;

  // With STEP=1 DivLast is 0 and div_q never leaves 0, so tick is always 1.
  assign tick = (div_q == DivLast);

  // Thermometer code: the lowest kv bits set.
  function automatic logic [N-1:0] therm(logic [KW-1:0] kv);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) begin
      t[i] = (KW'(i) < kv);
    end
    return t;
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          // Hazard first; L and R together count as a hazard request.
          if (H || (L && R)) begin
            state_d = StHaz;
            k_d     = '0;
          end else if (R) begin
            state_d = StRight;
            k_d     = KW'(1);
          end else if (L) begin
            state_d = StLeft;
            k_d     = KW'(1);
          end
        end
        StLeft: begin
          if (H || (k_q == KMax) || !L) begin
            state_d = StIdle;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        StRight: begin
          if (H || (k_q == KMax) || !R) begin
            state_d = StIdle;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        StHaz: begin
          state_d = StIdle;
          k_d     = '0;
        end
        default: begin
          state_d = StIdle;
          k_d     = '0;
        end
      endcase
    end
  end

  // Lamp pattern and busy are registered from the next state so they change
  // on the same edge as the state itself.
  always_ff @(posedge clk_1hz) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      div_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      div_q   <= tick ? '0 : div_q + DivW'(1);
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= (state_d != StIdle);
      left_q  <= (state_d == StHaz)  ? '1 :
                 (state_d == StLeft) ? therm(k_d) : '0;
      right_q <= (state_d == StHaz)   ? '1 :
                 (state_d == StRight) ? therm(k_d) : '0;
    end
  end

  // Brake lights whichever side is not sweeping; HAZ is already all-ones.
  assign Left  = left_q  | {N{B && (state_q != StLeft)}};
  assign Right = right_q | {N{B && (state_q != StRight)}};
  assign busy  = busy_q;

endmodule
